// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command codes and state encodings shared by the LCD refresh controller.
package lcd_pkg;
   localparam logic [7:0] FUNC_SET = 8'h38;
   localparam logic [7:0] DISP_ON  = 8'h0C;
   localparam logic [7:0] DISP_CUR = 8'h0E;
   localparam logic [7:0] ENTRY    = 8'h06;
   localparam logic [7:0] CLEAR    = 8'h01;
   localparam logic [7:0] LINE1    = 8'h80;
   localparam logic [7:0] LINE2    = 8'hC0;
   typedef enum logic [2:0] {
      ST_PWRUP, ST_INIT, ST_LINE1, ST_LINE2, ST_DRAIN, ST_FETCH, ST_CURSOR, ST_ENDW
   } state_e;
   typedef enum logic [2:0] {WR_IDLE, WR_SETUP, WR_EN, WR_HOLD, WR_WAIT} wr_state_e;
   function automatic int max2(input int a, input int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: one LCD byte transaction, SETUP -> EN -> HOLD -> WAIT by counted delays.
// A new start is accepted when idle or on the last WAIT cycle, so back-to-back bytes have no gap.
module lcd_byte_writer
   import lcd_pkg::*;
#(
   parameter int T_SETUP = 2,
   parameter int T_EN    = 13,
   parameter int T_HOLD  = 2,
   parameter int T_WAIT  = 2000,
   parameter int T_CLEAR = 82000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_i,
   input  logic [7:0] byte_i,
   input  logic       rs_i,
   input  logic       long_i,
   output logic       ready_o,
   output logic       done_o,
   output logic [7:0] data_o,
   output logic       rs_o,
   output logic       en_o
);
   localparam int CW = $clog2(max2(max2(max2(T_SETUP, T_EN), max2(T_HOLD, T_WAIT)), T_CLEAR) + 1);

   wr_state_e st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0] data_q, data_d;
   logic rs_q, rs_d, long_q, long_d;

   assign done_o  = (st_q == WR_WAIT) && (cnt_q == (long_q ? CW'(T_CLEAR - 1) : CW'(T_WAIT - 1)));
   assign ready_o = (st_q == WR_IDLE) || done_o;
   assign data_o  = data_q;
   assign rs_o    = rs_q;
   assign en_o    = (st_q == WR_EN);

   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q + 1'b1;
      data_d = data_q;
      rs_d   = rs_q;
      long_d = long_q;
      case (st_q)
         WR_SETUP: if (cnt_q == CW'(T_SETUP - 1)) begin st_d = WR_EN;   cnt_d = '0; end
         WR_EN:    if (cnt_q == CW'(T_EN - 1))    begin st_d = WR_HOLD; cnt_d = '0; end
         WR_HOLD:  if (cnt_q == CW'(T_HOLD - 1))  begin st_d = WR_WAIT; cnt_d = '0; end
         WR_WAIT:  if (done_o)                    begin st_d = WR_IDLE; cnt_d = '0; end
         default:  cnt_d = '0;
      endcase
      if (start_i && ready_o) begin
         st_d   = WR_SETUP;
         cnt_d  = '0;
         data_d = byte_i;
         rs_d   = rs_i;
         long_d = long_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q   <= WR_IDLE;
         cnt_q  <= '0;
         data_q <= 8'h00;
         rs_q   <= 1'b0;
         long_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         data_q <= data_d;
         rs_q   <= rs_d;
         long_q <= long_d;
      end
   end
endmodule

// File: rtl/lcd_refresh_ctrl.sv
// lcd_refresh_ctrl: powers up a 16x2 HD44780 LCD and streams the 32-byte character buffer forever.
// Optional LCD_CURSOR_EN: adds cursor_addr, shows the underline cursor and repositions it each frame.
module lcd_refresh_ctrl
   import lcd_pkg::*;
#(
   parameter int T_PWRUP = 750000,
   parameter int T_SETUP = 2,
   parameter int T_EN    = 13,
   parameter int T_HOLD  = 2,
   parameter int T_WAIT  = 2000,
   parameter int T_CLEAR = 82000
) (
`ifdef LCD_CURSOR_EN
   input  logic [4:0] cursor_addr,
`endif
   input  logic       clk,
   input  logic       reset,
   output logic [4:0] raddr,
   input  logic [7:0] rdata,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic       lcd_on,
   output logic       lcd_blon,
   output logic       frame_done
);
   localparam int PW = $clog2(T_PWRUP + 1);
`ifdef LCD_CURSOR_EN
   localparam logic [7:0] DISP_CMD = DISP_CUR;
   localparam state_e AFTER_LAST = ST_CURSOR;
`else
   localparam logic [7:0] DISP_CMD = DISP_ON;
   localparam state_e AFTER_LAST = ST_ENDW;
`endif

   state_e state_q, state_d;
   logic [PW-1:0] pw_q, pw_d;
   logic [1:0] idx_q, idx_d;
   logic [4:0] addr_q, addr_d, raddr_q, raddr_d;
   logic frame_done_q, frame_done_d;
   logic start, wrs, wlong, ready, done;
   logic [7:0] wbyte;

   lcd_byte_writer #(
      .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD), .T_WAIT(T_WAIT), .T_CLEAR(T_CLEAR)
   ) u_writer (
      .clk(clk), .reset(reset), .start_i(start), .byte_i(wbyte), .rs_i(wrs), .long_i(wlong),
      .ready_o(ready), .done_o(done), .data_o(lcd_data), .rs_o(lcd_rs), .en_o(lcd_en)
   );

   assign raddr      = raddr_q;
   assign frame_done = frame_done_q;
   assign lcd_rw     = 1'b0;
   assign lcd_on     = 1'b1;
   assign lcd_blon   = 1'b0;

   // Command states issue as soon as the writer is ready; FETCH is entered only once the
   // previous byte has fully completed, giving the buffer one cycle of read access.
   always_comb begin
      state_d      = state_q;
      pw_d         = pw_q;
      idx_d        = idx_q;
      addr_d       = addr_q;
      raddr_d      = raddr_q;
      frame_done_d = (state_q == ST_ENDW) && done;
      start        = 1'b0;
      wbyte        = 8'h00;
      wrs          = 1'b0;
      wlong        = 1'b0;
      case (state_q)
         ST_PWRUP: begin
            pw_d = pw_q + 1'b1;
            if (pw_q == PW'(T_PWRUP - 1)) state_d = ST_INIT;
         end
         ST_INIT: begin
            start = ready;
            wbyte = idx_q == 2'd0 ? FUNC_SET : idx_q == 2'd1 ? DISP_CMD : idx_q == 2'd2 ? ENTRY : CLEAR;
            wlong = idx_q == 2'd3;
            if (ready) begin
               idx_d = idx_q + 1'b1;
               if (idx_q == 2'd3) state_d = ST_LINE1;
            end
         end
         ST_LINE1, ST_LINE2: begin
            start = ready;
            wbyte = state_q == ST_LINE1 ? LINE1 : LINE2;
            if (ready) state_d = ST_DRAIN;
         end
         ST_DRAIN: if (done) begin
            state_d = ST_FETCH;
            raddr_d = addr_q;
         end
         ST_FETCH: begin
            start   = 1'b1;
            wbyte   = rdata;
            wrs     = 1'b1;
            addr_d  = addr_q + 5'd1;
            state_d = addr_q == 5'd15 ? ST_LINE2 : addr_q == 5'd31 ? AFTER_LAST : ST_DRAIN;
         end
`ifdef LCD_CURSOR_EN
         ST_CURSOR: begin
            start = ready;
            wbyte = {1'b1, cursor_addr[4], 2'b00, cursor_addr[3:0]};
            if (ready) state_d = ST_ENDW;
         end
`endif
         ST_ENDW: if (done) state_d = ST_LINE1;
         default: state_d = ST_PWRUP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_PWRUP;
         pw_q         <= '0;
         idx_q        <= 2'd0;
         addr_q       <= 5'd0;
         raddr_q      <= 5'd0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pw_q         <= pw_d;
         idx_q        <= idx_d;
         addr_q       <= addr_d;
         raddr_q      <= raddr_d;
         frame_done_q <= frame_done_d;
      end
   end
endmodule
